// File: rtl/ls_stage_pkg.sv
// ls_stage_pkg
// Shared definitions for the load/store stage: default widths, opcode and
// funct3 encodings, access-size codes, FSM state encoding and two small
// helpers (byte-lane mask and natural-alignment test).
package ls_stage_pkg;

  localparam int LS_XLEN     = 64;
  localparam int LS_INST_LEN = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 encodings (instr[14:12]); bit 2 on a load selects zero-extension
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size codes (funct3[1:0])
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } ls_state_e;

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the byte offset is a multiple of the access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ls_stage_if.sv
// ls_stage_if
// Data-memory port of the load/store stage.
//   mem_req    master->slave  request; addr/we/wdata/wmask stable while high
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  8-byte-aligned address
//   mem_wdata  master->slave  write data, already shifted into its byte lanes
//   mem_wmask  master->slave  byte enables
//   mem_gnt    slave->master  request accepted
//   mem_rvalid slave->master  response (read data or write ack)
//   mem_rdata  slave->master  read data, 8-byte aligned
interface ls_stage_if
  import ls_stage_pkg::*;
#(
  parameter int XLEN = LS_XLEN
) ();

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ls_load_align.sv
// ls_load_align
// Combinational load-data alignment: shifts the addressed bytes of an
// 8-byte-aligned memory word down to bit 0, truncates to the access size and
// sign- or zero-extends to XLEN.
//   rdata  in   XLEN  aligned read data
//   off    in   3     byte offset within the word
//   size   in   2     access size code (B/H/W/D)
//   zext   in   1     1 = zero-extend, 0 = sign-extend
//   data   out  XLEN  aligned, extended load result
module ls_load_align
  import ls_stage_pkg::*;
#(
  parameter int XLEN = LS_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            zext,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;
  logic            sign;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    sign    = 1'b0;
    data    = shifted;
    case (size)
      SZ_B: begin
        sign = ~zext & shifted[7];
        data = {{(XLEN-8){sign}}, shifted[7:0]};
      end
      SZ_H: begin
        sign = ~zext & shifted[15];
        data = {{(XLEN-16){sign}}, shifted[15:0]};
      end
      SZ_W: begin
        sign = ~zext & shifted[31];
        data = {{(XLEN-32){sign}}, shifted[31:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/ls_stage.sv
// ls_stage
// Load/store pipeline stage. Non-memory instructions pass alures_i to
// writeback one cycle later. Aligned loads/stores are captured, issued on the
// memory port, and retired one cycle after the response. Misaligned accesses
// never reach memory: they pulse misalign_o and retire with data 0.
//   clk, rstn              clock, asynchronous active-low reset
//   valid_i                upstream register holds a live instruction
//   pc_i/rs2_i/alures_i    PC, store data, effective address / ALU result
//   instr_i                instruction
//   stall_o                freezes upstream while high
//   mem                    data-memory port (master side)
//   wb_valid/pc/instr/data retiring instruction toward writeback
//   misalign_o             one-cycle pulse for a misaligned access
//   state_o                current FSM state (debug)
//
// Handshake: mem_req rises in REQ and stays high, with addr/we/wdata/wmask
// frozen, until the cycle mem_gnt is sampled high. The response is the first
// cycle with mem_rvalid high at or after the grant cycle; gnt/rvalid seen in
// any other state are ignored.
module ls_stage
  import ls_stage_pkg::*;
#(
  parameter int XLEN     = LS_XLEN,
  parameter int INST_LEN = LS_INST_LEN
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic [XLEN-1:0]     alures_i,
  input  logic [INST_LEN-1:0] instr_i,
  output logic                stall_o,
  ls_stage_if.master          mem,
  output logic                wb_valid,
  output logic [XLEN-1:0]     wb_pc,
  output logic [INST_LEN-1:0] wb_instr,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign_o,
  output ls_state_e           state_o
);

  localparam int NB = XLEN / 8;

  ls_state_e state_q, state_d;

  // Decode of the incoming instruction
  logic is_mem_i, aligned_i, start_mem, misalign_i, pass_i;

  always_comb begin
    is_mem_i   = (instr_i[6:0] == OPC_LOAD) || (instr_i[6:0] == OPC_STORE);
    aligned_i  = is_aligned(instr_i[13:12], alures_i[2:0]);
    start_mem  = valid_i && is_mem_i && aligned_i;
    misalign_i = valid_i && is_mem_i && !aligned_i;
    pass_i     = valid_i && !is_mem_i;
  end

  // Captured memory instruction; held unchanged from IDLE until back in IDLE
  logic [XLEN-1:0]     pc_q, rs2_q, alures_q;
  logic [INST_LEN-1:0] instr_q;
  logic                load_q, store_q, zext_q;
  logic [1:0]          size_q;
  logic [2:0]          off_q;
  logic [XLEN-1:0]     load_data;
  logic                resp_take;

  assign load_q  = (instr_q[6:0] == OPC_LOAD);
  assign store_q = (instr_q[6:0] == OPC_STORE);
  assign size_q  = instr_q[13:12];
  assign zext_q  = instr_q[14];
  assign off_q   = alures_q[2:0];

  // Response accepted this cycle; a grant and response together in REQ
  // skip WAIT entirely.
  assign resp_take = ((state_q == S_REQ) && mem.mem_gnt && mem.mem_rvalid) ||
                     ((state_q == S_WAIT) && mem.mem_rvalid);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_mem) state_d = S_REQ;
      S_REQ: begin
        if (mem.mem_gnt) state_d = mem.mem_rvalid ? S_RESP : S_WAIT;
      end
      S_WAIT: if (mem.mem_rvalid) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. RESP does not stall: upstream advances as this instruction
  // retires.
  always_comb begin
    stall_o     = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    case (state_q)
      S_IDLE: stall_o = start_mem;
      S_REQ: begin
        stall_o     = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = store_q;
      end
      S_WAIT:  stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  assign state_o = state_q;

  // Memory request fields come only from captured registers, so they cannot
  // move while mem_req is high.
  assign mem.mem_addr  = {alures_q[XLEN-1:3], 3'b000};
  assign mem.mem_wdata = rs2_q << {off_q, 3'b000};
  assign mem.mem_wmask = NB'(size_mask(size_q)) << off_q;

  ls_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata (mem.mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .zext  (zext_q),
    .data  (load_data)
  );

  // Capture registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= '0;
      instr_q  <= '0;
      rs2_q    <= '0;
      alures_q <= '0;
    end else if (state_q == S_IDLE && start_mem) begin
      pc_q     <= pc_i;
      instr_q  <= instr_i;
      rs2_q    <= rs2_i;
      alures_q <= alures_i;
    end
  end

  // Writeback and misalign registers; wb_valid and misalign_o are pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      wb_instr   <= '0;
      wb_data    <= '0;
      misalign_o <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      if (state_q == S_IDLE && pass_i) begin
        wb_valid <= 1'b1;
        wb_pc    <= pc_i;
        wb_instr <= instr_i;
        wb_data  <= alures_i;
      end else if (state_q == S_IDLE && misalign_i) begin
        wb_valid   <= 1'b1;
        wb_pc      <= pc_i;
        wb_instr   <= instr_i;
        wb_data    <= '0;
        misalign_o <= 1'b1;
      end else if (resp_take) begin
        wb_valid <= 1'b1;
        wb_pc    <= pc_q;
        wb_instr <= instr_q;
        wb_data  <= load_q ? load_data : '0;
      end
    end
  end

endmodule
